// File: rtl/dma_auth_pkg.sv
// Shared types for the DMA tag-authentication path: sequencer states, tag
// field position and the pointer tag-stripping helper.
package dma_auth_pkg;

  localparam int TAG_HI = 63;
  localparam int TAG_LO = 48;
  localparam int HASH_W = 16;

  typedef logic [HASH_W-1:0] tag_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    RESP   = 3'd4
  } state_e;

  function automatic logic [63:0] strip_tag(input logic [63:0] ptr);
    return {16'h0000, ptr[TAG_LO-1:0]};
  endfunction

endpackage

// File: rtl/dma_tag_wdog.sv
// Cycle counter shared by the hash-engine watchdog and the post-timeout quiet
// period. Clear wins over enable; the count parks at its terminal value.
module dma_tag_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;
  logic          term_s;

  assign term_s   = (count_r == LAST);
  assign terminal = term_s;

  // Counter register: clear, count while enabled, hold at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en && !term_s) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/dma_tag_checker.sv
// Sequencer that strips the tag from a DMA pointer, launches the hash engine,
// compares its hash against the tag and reports an allow/deny verdict.
module dma_tag_checker
  import dma_auth_pkg::*;
#(
  parameter int ID_W           = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_enable,
  input  logic [127:0]      cfg_key,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_pointer,
  input  logic [127:0]      req_metadata,
  input  logic [ID_W-1:0]   req_id,
  output logic              he_start,
  output logic [127:0]      he_metadata,
  output logic [127:0]      he_key,
  output logic [63:0]       he_pointer,
  input  logic [HASH_W-1:0] he_hash,
  input  logic              he_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_allow,
  output logic              rsp_timeout,
  output logic [CNT_W-1:0]  fail_count
);

  state_e            state_r, state_s;
  logic              req_ready_r, he_start_r, rsp_valid_r;
  logic              allow_r, timeout_r, pending_r;
  logic [63:0]       ptr_r;
  logic [127:0]      meta_r, key_r;
  logic [ID_W-1:0]   id_r;
  tag_t              tag_r;
  logic [CNT_W-1:0]  fail_r;
  logic              accept_s, done_s, tmo_s, hs_s;
  logic              wdog_clr_s, wdog_en_s, wdog_term_s;

  dma_tag_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wdog_clr_s),
    .en       (wdog_en_s),
    .terminal (wdog_term_s)
  );

  // Next-state and event decode for the sequencer.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    done_s     = 1'b0;
    tmo_s      = 1'b0;
    hs_s       = 1'b0;
    wdog_clr_s = 1'b0;
    wdog_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = cfg_enable ? LAUNCH : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        wdog_clr_s = 1'b1;
        state_s    = WAIT;
      end
      WAIT: begin
        wdog_en_s = 1'b1;
        // A result on the terminal cycle still counts as a normal compare.
        if (he_done) begin
          done_s  = 1'b1;
          state_s = RESP;
        end else if (wdog_term_s) begin
          tmo_s      = 1'b1;
          wdog_clr_s = 1'b1;
          state_s    = DRAIN;
        end else begin
          state_s = WAIT;
        end
      end
      DRAIN: begin
        wdog_en_s = 1'b1;
        if (he_done || wdog_term_s) begin
          state_s = pending_r ? RESP : IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          hs_s    = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = DRAIN;
      end
    endcase
  end

  // State and handshake outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DRAIN;
      req_ready_r <= 1'b0;
      he_start_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == IDLE);
      he_start_r  <= (state_s == LAUNCH);
      rsp_valid_r <= (state_s == RESP);
    end
  end

  // Request capture and verdict registers; held untouched until next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= 64'h0;
      meta_r    <= 128'h0;
      key_r     <= 128'h0;
      id_r      <= {ID_W{1'b0}};
      tag_r     <= {HASH_W{1'b0}};
      allow_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else if (accept_s) begin
      ptr_r     <= strip_tag(req_pointer);
      meta_r    <= req_metadata;
      key_r     <= cfg_key;
      id_r      <= req_id;
      tag_r     <= req_pointer[TAG_HI:TAG_LO];
      allow_r   <= !cfg_enable;
      timeout_r <= 1'b0;
    end else if (done_s) begin
      allow_r   <= (he_hash == tag_r);
      timeout_r <= 1'b0;
    end else if (tmo_s) begin
      allow_r   <= 1'b0;
      timeout_r <= 1'b1;
    end
  end

  // Pending-verdict flag (DRAIN after a timeout vs. DRAIN after reset) and deny counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
      fail_r    <= {CNT_W{1'b0}};
    end else begin
      if (tmo_s) begin
        pending_r <= 1'b1;
      end else if ((state_r == DRAIN) && (state_s != DRAIN)) begin
        pending_r <= 1'b0;
      end
      if (hs_s && !allow_r && (fail_r != {CNT_W{1'b1}})) begin
        fail_r <= fail_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign he_start    = he_start_r;
  assign he_pointer  = ptr_r;
  assign he_metadata = meta_r;
  assign he_key      = key_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_id      = id_r;
  assign rsp_allow   = allow_r;
  assign rsp_timeout = timeout_r;
  assign fail_count  = fail_r;

endmodule

// File: tb/tb_dma_tag_checker.sv
// Self-checking bench for dma_tag_checker: directed vector table, hand-written
// reset/drain sequences and randomized transactions against a transaction model.
module tb_dma_tag_checker;

  localparam int TC = 64;

  logic         clk = 1'b0;
  logic         rst_n, cfg_enable, req_valid, he_done, rsp_ready;
  logic [127:0] cfg_key, req_metadata;
  logic [63:0]  req_pointer;
  logic [3:0]   req_id;
  logic [15:0]  he_hash;
  logic         req_ready, he_start, rsp_valid, rsp_allow, rsp_timeout;
  logic [127:0] he_metadata, he_key;
  logic [63:0]  he_pointer;
  logic [3:0]   rsp_id;
  logic [15:0]  fail_count;
  logic         req_ready2, he_start2, rsp_valid2, rsp_allow2, rsp_timeout2;
  logic [127:0] he_metadata2, he_key2;
  logic [63:0]  he_pointer2;
  logic [3:0]   rsp_id2;
  logic [1:0]   fail_count2;

  always #5 clk = ~clk;

  dma_tag_checker #(.ID_W(4), .TIMEOUT_CYCLES(TC), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_key(cfg_key),
    .req_valid(req_valid), .req_ready(req_ready), .req_pointer(req_pointer),
    .req_metadata(req_metadata), .req_id(req_id), .he_start(he_start),
    .he_metadata(he_metadata), .he_key(he_key), .he_pointer(he_pointer),
    .he_hash(he_hash), .he_done(he_done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_allow(rsp_allow),
    .rsp_timeout(rsp_timeout), .fail_count(fail_count)
  );

  // Same stimulus, 2-bit deny counter to exercise saturation.
  dma_tag_checker #(.ID_W(4), .TIMEOUT_CYCLES(TC), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_key(cfg_key),
    .req_valid(req_valid), .req_ready(req_ready2), .req_pointer(req_pointer),
    .req_metadata(req_metadata), .req_id(req_id), .he_start(he_start2),
    .he_metadata(he_metadata2), .he_key(he_key2), .he_pointer(he_pointer2),
    .he_hash(he_hash), .he_done(he_done), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id2), .rsp_allow(rsp_allow2),
    .rsp_timeout(rsp_timeout2), .fail_count(fail_count2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_fail = 0;

  typedef struct {
    bit          en;
    logic [63:0] ptr;
    logic [15:0] hash;
    int          d;      // he_start-to-he_done distance, 0 = never
    int          stall;
    bit          exp_allow;
    bit          exp_tmo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycles from he_start to rsp_valid: result in WAIT or a stray result in DRAIN
  // ends early, otherwise 64 WAIT + 64 DRAIN cycles.
  function automatic int rsp_offset(input int d);
    if (d >= 1 && d <= 2 * TC) return d + 1;
    return 2 * TC + 1;
  endfunction

  task automatic run_txn(input bit en, input logic [63:0] ptr, input logic [15:0] hash,
                         input int d, input int stall, input bit exp_allow,
                         input bit exp_tmo, input logic [3:0] id);
    int t0, s, got, exp_c, starts, hold_err, bp_err;
    logic [127:0] meta, key;
    logic [63:0] exp_ptr;
    meta    = {$urandom, $urandom, $urandom, $urandom};
    key     = {$urandom, $urandom, $urandom, $urandom};
    exp_ptr = {16'h0000, ptr[47:0]};
    t0 = cyc;
    while (!req_ready && cyc < t0 + 300) step();
    chk("ready_wait", req_ready, 1'b1);
    cfg_enable = en; req_valid = 1'b1; req_pointer = ptr;
    req_metadata = meta; cfg_key = key; req_id = id; he_hash = hash;
    step();
    s = cyc;
    req_valid = 1'b0; req_pointer = ~ptr; req_metadata = ~meta; cfg_enable = ~en;
    if (en) begin
      chk("he_pointer", he_pointer, exp_ptr);
      chk("he_key", he_key, key);
      chk("he_metadata", he_metadata, meta);
    end
    exp_c = en ? s + rsp_offset(d) : s;
    got = -1; starts = 0; hold_err = 0;
    while (cyc <= s + 3 * TC + 10) begin
      if (he_start) starts++;
      if (en && (he_pointer !== exp_ptr || he_key !== key || he_metadata !== meta)) hold_err++;
      if (rsp_valid) begin
        got = cyc;
        break;
      end
      he_done = en && (d > 0) && (cyc == s + d);
      step();
    end
    he_done = 1'b0;
    chk("he_start_pulses", starts, en ? 1 : 0);
    chk("he_hold", hold_err, 0);
    chk("rsp_cycle", got, exp_c);
    chk("rsp_allow", rsp_allow, exp_allow);
    chk("rsp_timeout", rsp_timeout, exp_tmo);
    chk("rsp_id", rsp_id, id);
    bp_err = 0;
    for (int k = 0; k < stall; k++) begin
      req_valid = 1'b1;
      step();
      if (!rsp_valid || rsp_allow !== exp_allow || rsp_timeout !== exp_tmo ||
          rsp_id !== id || req_ready || he_start) bp_err++;
    end
    if (stall > 0) chk("backpressure", bp_err, 0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (!exp_allow) model_fail++;
    chk("rsp_dropped", rsp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
    chk("fail_count", fail_count, model_fail);
    chk("fail_count_sat", fail_count2, (model_fail > 3) ? 3 : model_fail);
  endtask

  initial begin
    int k, errs, hits;
    rst_n = 1'b0; cfg_enable = 1'b0; req_valid = 1'b0; he_done = 1'b0; rsp_ready = 1'b0;
    cfg_key = 128'h0; req_metadata = 128'h0; req_pointer = 64'h0; req_id = 4'h0; he_hash = 16'h0;
    step(); step();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_he_start", he_start, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_allow", rsp_allow, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_fail_count", fail_count, 16'h0);
    chk("rst_he_pointer", he_pointer, 64'h0);
    rst_n = 1'b1;
    k = 0;
    while (!req_ready && k < 200) begin
      step();
      k++;
    end
    chk("drain_after_reset", k, 64);

    tbl[0] = '{1'b1, 64'hBEEF_0000_1234_5000, 16'hBEEF, 12,  0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 64'hBEEF_0000_0000_1000, 16'hBEEE, 3,   0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 64'h1234_0000_0000_2000, 16'h1234, 0,   0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 64'hCAFE_0000_0000_3000, 16'hCAFE, 5,   5, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 64'hDEAD_0000_0000_4000, 16'h0000, 0,   0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 64'h5A5A_0000_0000_5000, 16'h5A5A, 64,  0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 64'h5A5A_0000_0000_6000, 16'h5A5A, 65,  0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 64'h0001_0000_0000_7000, 16'h0000, 1,   0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 64'h7777_0000_0000_8000, 16'h7777, 100, 2, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].en, tbl[i].ptr, tbl[i].hash, tbl[i].d, tbl[i].stall,
              tbl[i].exp_allow, tbl[i].exp_tmo, 4'(i));
    end
    chk("saturated", fail_count2, 2'b11);

    // Stray results while idle must not produce another response.
    hits = 0;
    for (int j = 0; j < 10; j++) begin
      he_done = (j == 2 || j == 5);
      step();
      if (rsp_valid) hits++;
    end
    he_done = 1'b0;
    chk("no_second_rsp", hits, 0);

    // Reset in the middle of WAIT, then a late result while draining.
    t_reset_mid_wait: begin
      k = cyc;
      while (!req_ready && cyc < k + 300) step();
      cfg_enable = 1'b1; req_valid = 1'b1; req_pointer = 64'hABCD_0000_0000_9000;
      req_id = 4'hA; he_hash = 16'hABCD;
      step();
      req_valid = 1'b0;
      for (int j = 0; j < 5; j++) step();
      rst_n = 1'b0;
      #1;
      model_fail = 0;
      chk("midrst_req_ready", req_ready, 1'b0);
      chk("midrst_rsp_valid", rsp_valid, 1'b0);
      chk("midrst_fail_count", fail_count, 16'h0);
      step(); step();
      rst_n = 1'b1;
      errs = 0; hits = 0;
      for (int j = 0; j < 15; j++) begin
        if (req_ready !== (j >= 11)) errs++;
        if (rsp_valid || he_start) hits++;
        he_done = (j == 10);
        step();
      end
      he_done = 1'b0;
      chk("midrst_drain_ready", errs, 0);
      chk("midrst_no_rsp", hits, 0);
    end

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      bit en, match, ea, et;
      logic [63:0] ptr;
      logic [15:0] hash;
      int d, r;
      en    = ($urandom_range(0, 3) != 0);
      ptr   = {$urandom, $urandom};
      match = $urandom_range(0, 1);
      hash  = match ? ptr[63:48] : (ptr[63:48] ^ (16'h1 << $urandom_range(0, 15)));
      r = $urandom_range(0, 9);
      d = (r < 6) ? $urandom_range(1, TC) : (r < 8) ? $urandom_range(TC + 1, 140) : 0;
      ea = !en || (d >= 1 && d <= TC && hash == ptr[63:48]);
      et = en && !(d >= 1 && d <= TC);
      run_txn(en, ptr, hash, d, $urandom_range(0, 3), ea, et, 4'(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
